// File: rtl/trig_pkg.sv
// Shared state encoding, config register map and reset defaults for trigger_seq.
package trig_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    PULSE0  = 3'd2,
    PULSE1  = 3'd3,
    TRIGGER = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_LEVEL0  = 3'd1;
  localparam logic [2:0] ADDR_LEVEL1  = 3'd2;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
  localparam logic [2:0] ADDR_MULT    = 3'd5;

  localparam logic [7:0]  MULT_RST    = 8'd20;
  localparam logic [23:0] TIMEOUT_RST = 24'hFF_FFFF;
  localparam int unsigned HOLDOFF_DEF = 500000;

endpackage

// File: rtl/trig_channel_eval.sv
// One ADC channel: registered pair sum, level compares against both thresholds,
// and single-cycle edge events on each compare.
module trig_channel_eval #(
  parameter int unsigned ADC_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2*ADC_DATA_WIDTH-1:0]   data,
  input  logic [15:0]                   level0,
  input  logic [15:0]                   level1,
  output logic [1:0]                    ev_rise,
  output logic [1:0]                    ev_fall
);

  localparam int unsigned W = ADC_DATA_WIDTH;

  logic signed [W:0]  sum_d, sum_q;
  logic signed [16:0] lvl0_x2, lvl1_x2;
  logic [1:0]         gt_d, gt_q, lt_d, lt_q;
  logic [1:0]         rise_d, rise_q, fall_d, fall_q;

  always_comb begin
    sum_d = sum_q;
    if (en) begin
      sum_d = $signed({data[W-1], data[W-1:0]}) + $signed({data[2*W-1], data[2*W-1:W]});
    end
    lvl0_x2 = $signed({level0, 1'b0});
    lvl1_x2 = $signed({level1, 1'b0});
    gt_d[0] = sum_q > lvl0_x2;
    gt_d[1] = sum_q > lvl1_x2;
    lt_d[0] = sum_q < lvl0_x2;
    lt_d[1] = sum_q < lvl1_x2;
    rise_d  = gt_d & ~gt_q;
    fall_d  = lt_d & ~lt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      gt_q   <= '0;
      lt_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sum_q  <= sum_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign ev_rise = rise_q;
  assign ev_fall = fall_q;

endmodule

// File: rtl/trigger_seq.sv
// N-channel pulse-pair trigger sequencer: first/second edge detection,
// scaled inter-pulse delay, delayed trigger, holdoff, timeout and re-arm.
module trigger_seq
  import trig_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned ADC_DATA_WIDTH = 16,
  parameter int unsigned WAIT_WIDTH     = 24,
  parameter int unsigned HOLDOFF_RST    = HOLDOFF_DEF
) (
  input  logic                             adc_clk,
  input  logic                             trig_reset,
  input  logic [N_CH*2*ADC_DATA_WIDTH-1:0] adc_data,
  input  logic [N_CH-1:0]                  adc_enable,
  input  logic                             cfg_wrt,
  input  logic [2:0]                       cfg_addr,
  input  logic [31:0]                      cfg_data,
  output logic                             trigger0,
  output logic                             trigger1,
  output logic [15:0]                      pulse_delay,
  output logic                             timeout_flag,
  output logic [15:0]                      trig_count,
  output logic [2:0]                       state_o
);

  logic [8:0]            ctrl_d, ctrl_q;
  logic [15:0]           level0_d, level0_q, level1_d, level1_q;
  logic [WAIT_WIDTH-1:0] holdoff_d, holdoff_q, timeout_d, timeout_q;
  logic [7:0]            mult_d, mult_q;

  state_e                state_d, state_q;
  logic [WAIT_WIDTH-1:0] wait_d, wait_q;
  logic [WAIT_WIDTH:0]   acc;
  logic [15:0]           pulse_delay_d, pulse_delay_q, trig_count_d, trig_count_q;
  logic                  timeout_flag_d, timeout_flag_q;
  logic                  trigger0_d, trigger0_q, trigger1_d, trigger1_q;

  logic [1:0]            rise_ev [N_CH];
  logic [1:0]            fall_ev [N_CH];
  logic [2:0]            idx0, idx1;
  logic                  ev0, ev1;
  logic                  unused_cfg;

  assign unused_cfg = ^cfg_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    trig_channel_eval #(.ADC_DATA_WIDTH(ADC_DATA_WIDTH)) u_eval (
      .clk     (adc_clk),
      .rst     (trig_reset),
      .en      (adc_enable[k]),
      .data    (adc_data[k*2*ADC_DATA_WIDTH +: 2*ADC_DATA_WIDTH]),
      .level0  (level0_q),
      .level1  (level1_q),
      .ev_rise (rise_ev[k]),
      .ev_fall (fall_ev[k])
    );
  end

  // Channel/polarity select; out-of-range selects fall back to channel 0.
  always_comb begin
    idx0 = (32'(ctrl_q[2:0]) >= N_CH) ? 3'd0 : ctrl_q[2:0];
    idx1 = (32'(ctrl_q[5:3]) >= N_CH) ? 3'd0 : ctrl_q[5:3];
    ev0  = 1'b0;
    ev1  = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(idx0) == k) ev0 = ctrl_q[6] ? rise_ev[k][0] : fall_ev[k][0];
      if (32'(idx1) == k) ev1 = ctrl_q[7] ? rise_ev[k][1] : fall_ev[k][1];
    end
  end

  // Config register writes.
  always_comb begin
    ctrl_d    = ctrl_q;
    level0_d  = level0_q;
    level1_d  = level1_q;
    holdoff_d = holdoff_q;
    timeout_d = timeout_q;
    mult_d    = mult_q;
    if (cfg_wrt) begin
      case (cfg_addr)
        ADDR_CTRL:    ctrl_d    = cfg_data[8:0];
        ADDR_LEVEL0:  level0_d  = cfg_data[15:0];
        ADDR_LEVEL1:  level1_d  = cfg_data[15:0];
        ADDR_HOLDOFF: holdoff_d = cfg_data[WAIT_WIDTH-1:0];
        ADDR_TIMEOUT: timeout_d = cfg_data[WAIT_WIDTH-1:0];
        ADDR_MULT:    mult_d    = cfg_data[7:0];
        default:      ;
      endcase
    end
  end

  // Sequencer next state, wait counter and registered outputs.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pulse_delay_d  = pulse_delay_q;
    trig_count_d   = trig_count_q;
    timeout_flag_d = timeout_flag_q;
    acc            = {1'b0, wait_q} + (WAIT_WIDTH+1)'(mult_q);
    case (state_q)
      IDLE: begin
        if (wait_q == '0) state_d = READY;
        else              wait_d  = wait_q - WAIT_WIDTH'(1);
      end
      READY: begin
        wait_d = '0;
        if (ev0) state_d = PULSE0;
      end
      PULSE0: begin
        // event1 takes priority over timeout; the counter is held on capture
        if (ev1) begin
          pulse_delay_d = wait_q[15:0];
          state_d       = PULSE1;
        end else if (wait_q >= timeout_q) begin
          timeout_flag_d = 1'b1;
          wait_d         = holdoff_q;
          state_d        = IDLE;
        end else begin
          wait_d = acc[WAIT_WIDTH] ? '1 : acc[WAIT_WIDTH-1:0];
        end
      end
      PULSE1: begin
        if (wait_q == '0) begin
          state_d      = TRIGGER;
          trig_count_d = trig_count_q + 16'd1;
        end else begin
          wait_d = wait_q - WAIT_WIDTH'(1);
        end
      end
      TRIGGER: begin
        if (ctrl_q[8]) begin
          wait_d  = holdoff_q;
          state_d = IDLE;
        end
      end
      default: begin
        wait_d  = holdoff_q;
        state_d = IDLE;
      end
    endcase
    trigger0_d = (state_d == READY);
    trigger1_d = (state_d == PULSE1);
  end

  // State, counters and configuration registers.
  always_ff @(posedge adc_clk) begin
    if (trig_reset) begin
      ctrl_q         <= '0;
      level0_q       <= '0;
      level1_q       <= '0;
      holdoff_q      <= WAIT_WIDTH'(HOLDOFF_RST);
      timeout_q      <= '1;
      mult_q         <= MULT_RST;
      state_q        <= IDLE;
      wait_q         <= WAIT_WIDTH'(HOLDOFF_RST);
      pulse_delay_q  <= '0;
      trig_count_q   <= '0;
      timeout_flag_q <= 1'b0;
      trigger0_q     <= 1'b0;
      trigger1_q     <= 1'b0;
    end else begin
      ctrl_q         <= ctrl_d;
      level0_q       <= level0_d;
      level1_q       <= level1_d;
      holdoff_q      <= holdoff_d;
      timeout_q      <= timeout_d;
      mult_q         <= mult_d;
      state_q        <= state_d;
      wait_q         <= wait_d;
      pulse_delay_q  <= pulse_delay_d;
      trig_count_q   <= trig_count_d;
      timeout_flag_q <= timeout_flag_d;
      trigger0_q     <= trigger0_d;
      trigger1_q     <= trigger1_d;
    end
  end

  assign trigger0     = trigger0_q;
  assign trigger1     = trigger1_q;
  assign pulse_delay  = pulse_delay_q;
  assign timeout_flag = timeout_flag_q;
  assign trig_count   = trig_count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Directed bench for trigger_seq: edge-detect vector table plus hand-written
// sequences for delay scaling, timeout, re-arm and mid-sequence reset.
module tb_trigger_seq;

  localparam int unsigned NCH = 4;

  logic              adc_clk = 1'b0;
  logic              trig_reset;
  logic [NCH*32-1:0] adc_data;
  logic [NCH-1:0]    adc_enable;
  logic              cfg_wrt;
  logic [2:0]        cfg_addr;
  logic [31:0]       cfg_data;
  logic              trigger0, trigger1, timeout_flag;
  logic [15:0]       pulse_delay, trig_count;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_fail   = 0;

  trigger_seq #(
    .N_CH(NCH), .ADC_DATA_WIDTH(16), .WAIT_WIDTH(24), .HOLDOFF_RST(10)
  ) dut (
    .adc_clk(adc_clk), .trig_reset(trig_reset), .adc_data(adc_data),
    .adc_enable(adc_enable), .cfg_wrt(cfg_wrt), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .trigger0(trigger0), .trigger1(trigger1),
    .pulse_delay(pulse_delay), .timeout_flag(timeout_flag),
    .trig_count(trig_count), .state_o(state_o)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    logic [2:0]  sel;
    logic        pol;
    logic [15:0] lvl;
    int          ch;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        en;
    logic        exp_ev;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] s0, input logic [15:0] s1);
    adc_data[ch*32 +: 32] = {s1, s0};
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_wrt  = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_wrt  = 1'b0;
  endtask

  task automatic do_reset();
    trig_reset = 1'b1;
    tick();
    tick();
    trig_reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40; i++) begin
      if (state_o == 3'd1) break;
      tick();
    end
    check(name, state_o, 3'd1);
  endtask

  task automatic count_trigger1(output int cnt);
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!trigger1) break;
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    trig_reset = 1'b1;
    adc_data   = '0;
    adc_enable = '1;
    cfg_wrt    = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;

    //            sel   pol   lvl        ch  s0         s1         en    exp
    vecs[0] = '{3'd1, 1'b1, 16'd100,   1, 16'd120,   16'd120,   1'b1, 1'b1};
    vecs[1] = '{3'd1, 1'b1, 16'd100,   1, 16'd100,   16'd100,   1'b1, 1'b0};
    vecs[2] = '{3'd1, 1'b1, 16'd100,   1, 16'd100,   16'd101,   1'b1, 1'b1};
    vecs[3] = '{3'd2, 1'b0, 16'hFF9C,  2, 16'hFF9C,  16'hFF9B,  1'b1, 1'b1};
    vecs[4] = '{3'd2, 1'b0, 16'hFF9C,  2, 16'hFF9C,  16'hFF9C,  1'b1, 1'b0};
    vecs[5] = '{3'd5, 1'b1, 16'd0,     0, 16'd1,     16'd0,     1'b1, 1'b1};
    vecs[6] = '{3'd3, 1'b1, 16'd0,     2, 16'd100,   16'd100,   1'b1, 1'b0};
    vecs[7] = '{3'd3, 1'b1, 16'd0,     3, 16'd100,   16'd100,   1'b0, 1'b0};
    vecs[8] = '{3'd0, 1'b0, 16'h7FFF,  0, 16'hFFFB,  16'd3,     1'b1, 1'b1};
    vecs[9] = '{3'd3, 1'b1, 16'h8000,  3, 16'h8000,  16'h8001,  1'b1, 1'b1};

    // Reset values and holdoff exit timing
    tick();
    tick();
    check("rst_trigger0", trigger0, 0);
    check("rst_trigger1", trigger1, 0);
    check("rst_pulse_delay", pulse_delay, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    check("rst_trig_count", trig_count, 0);
    check("rst_state", state_o, 0);
    trig_reset = 1'b0;
    repeat (10) tick();
    check("holdoff_10_trigger0", trigger0, 0);
    check("holdoff_10_state", state_o, 0);
    tick();
    check("holdoff_11_trigger0", trigger0, 1);
    check("holdoff_11_state", state_o, 1);

    // Edge-detect vector table
    for (int i = 0; i < 10; i++) begin
      adc_enable = '1;
      for (int c = 0; c < int'(NCH); c++)
        if (vecs[i].pol) set_ch(c, 16'h8000, 16'h8000);
        else             set_ch(c, 16'h7FFF, 16'h7FFF);
      do_reset();
      wr(3'd0, {25'd0, vecs[i].pol, 3'd0, vecs[i].sel});
      wr(3'd1, {16'd0, vecs[i].lvl});
      wait_ready($sformatf("vec%0d_ready", i));
      adc_enable[vecs[i].ch] = vecs[i].en;
      set_ch(vecs[i].ch, vecs[i].s0, vecs[i].s1);
      tick();
      tick();
      check($sformatf("vec%0d_latency", i), state_o, 3'd1);
      tick();
      check($sformatf("vec%0d_state", i), state_o, vecs[i].exp_ev ? 3'd2 : 3'd1);
      check($sformatf("vec%0d_trigger0", i), trigger0, vecs[i].exp_ev ? 1'b0 : 1'b1);
    end
    adc_enable = '1;

    // Scaled delay: MULT=20, 10 PULSE0 cycles -> 200, trigger1 for 201 cycles
    adc_data = '0;
    set_ch(1, 16'd50, 16'd50);
    do_reset();
    wr(3'd0, 32'h51);
    wr(3'd1, 32'd100);
    wr(3'd2, 32'h0000FF9C);
    wait_ready("b_ready");
    set_ch(1, 16'd120, 16'd120);
    repeat (3) tick();
    check("b_pulse0", state_o, 3'd2);
    check("b_pulse0_trigger0", trigger0, 0);
    repeat (8) tick();
    set_ch(2, 16'hFF6A, 16'hFF6A);
    tick();
    tick();
    check("b_still_pulse0", state_o, 3'd2);
    tick();
    check("b_pulse1", state_o, 3'd3);
    check("b_pulse_delay", pulse_delay, 200);
    check("b_trigger1", trigger1, 1);
    count_trigger1(cnt);
    check("b_trigger1_width", cnt, 201);
    check("b_trigger_state", state_o, 3'd4);
    check("b_trig_count", trig_count, 1);
    repeat (5) tick();
    check("b_hold_trigger", state_o, 3'd4);
    check("b_hold_count", trig_count, 1);

    // Re-arm via mid-sequence write, second pair with MULT=0
    set_ch(1, 16'd50, 16'd50);
    set_ch(2, 16'd0, 16'd0);
    wr(3'd5, 32'd0);
    wr(3'd0, 32'h151);
    check("b_rearm_wait", state_o, 3'd4);
    tick();
    check("b_rearm_idle", state_o, 3'd0);
    wait_ready("b_ready2");
    set_ch(1, 16'd120, 16'd120);
    repeat (3) tick();
    check("b2_pulse0", state_o, 3'd2);
    set_ch(2, 16'hFF6A, 16'hFF6A);
    repeat (3) tick();
    check("b2_pulse1", state_o, 3'd3);
    check("b2_pulse_delay", pulse_delay, 0);
    count_trigger1(cnt);
    check("b2_trigger1_width", cnt, 1);
    check("b2_trig_count", trig_count, 2);
    check("b2_trigger_state", state_o, 3'd4);
    tick();
    check("b2_rearm_idle", state_o, 3'd0);

    // Timeout: TIMEOUT=100, MULT=20, no second pulse
    adc_data = '0;
    set_ch(1, 16'd50, 16'd50);
    do_reset();
    wr(3'd0, 32'h41);
    wr(3'd1, 32'd100);
    wr(3'd4, 32'd100);
    wait_ready("c_ready");
    set_ch(1, 16'd120, 16'd120);
    repeat (3) tick();
    check("c_pulse0", state_o, 3'd2);
    repeat (5) tick();
    check("c_pre_timeout_state", state_o, 3'd2);
    check("c_pre_timeout_flag", timeout_flag, 0);
    tick();
    check("c_timeout_state", state_o, 3'd0);
    check("c_timeout_flag", timeout_flag, 1);
    repeat (10) tick();
    check("c_holdoff_idle", state_o, 3'd0);
    tick();
    check("c_holdoff_ready", state_o, 3'd1);
    check("c_flag_sticky", timeout_flag, 1);
    repeat (5) tick();
    check("c_level_no_event", state_o, 3'd1);

    // Reset asserted during PULSE1
    adc_data = '0;
    set_ch(1, 16'd50, 16'd50);
    do_reset();
    wr(3'd0, 32'h51);
    wr(3'd1, 32'd100);
    wr(3'd2, 32'h0000FF9C);
    wait_ready("d_ready");
    set_ch(1, 16'd120, 16'd120);
    repeat (3) tick();
    repeat (4) tick();
    set_ch(2, 16'hFF6A, 16'hFF6A);
    repeat (3) tick();
    check("d_pulse1", state_o, 3'd3);
    check("d_pulse_delay", pulse_delay, 120);
    repeat (3) tick();
    trig_reset = 1'b1;
    tick();
    check("d_rst_trigger1", trigger1, 0);
    check("d_rst_state", state_o, 3'd0);
    check("d_rst_pulse_delay", pulse_delay, 0);
    trig_reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
